// File: rtl/banco_registros_param.sv
// banco_registros_param: parametrised register bank with NR combinational read
// ports, one synchronous write port, optional write-to-read bypass, optional
// hard-wired zero register and a sequential clear engine (one entry per cycle).
//
// Clear engine states:
//   state   | meaning
//   REPOSO  | idle; writes accepted, CLR_BRP starts a sweep
//   BARRIDO | sweeping; MEM[cnt] zeroed each edge, writes held off
//   FIN     | one-cycle completion pulse; writes accepted, CLR_BRP restarts
module banco_registros_param #(
    parameter int ANCHO   = 32,
    parameter int PROF    = 32,
    parameter int DIR_W   = $clog2(PROF),
    parameter int NR      = 2,
    parameter int CERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                  CLK_BRP,
    input  logic                  RST_N_BRP,
    input  logic [NR*DIR_W-1:0]   RA_BRP,
    output logic [NR*ANCHO-1:0]   DR_BRP,
    input  logic [DIR_W-1:0]      WA_BRP,
    input  logic [ANCHO-1:0]      DW_BRP,
    input  logic                  WE_BRP,
    output logic                  WACK_BRP,
    input  logic                  CLR_BRP,
    output logic                  OCUPADO_BRP,
    output logic                  FIN_BRP
);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        BARRIDO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [DIR_W-1:0]   cnt_q, cnt_d;
    logic [ANCHO-1:0]   mem_q [PROF];
    logic               wr_cero;

    // Writes are only held off while the sweep owns the storage.
    assign WACK_BRP = WE_BRP & ~OCUPADO_BRP;
    assign wr_cero  = (CERO_R0 != 0) && (WA_BRP == '0);

    // State and sweep counter register.
    always_ff @(posedge CLK_BRP or negedge RST_N_BRP) begin
        if (!RST_N_BRP) begin
            estado_q <= REPOSO;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: a started sweep always runs to PROF-1, CLR ignored inside it.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        unique case (estado_q)
            REPOSO, FIN: begin
                if (CLR_BRP) begin
                    estado_d = BARRIDO;
                    cnt_d    = '0;
                end else begin
                    estado_d = REPOSO;
                end
            end
            BARRIDO: begin
                if (cnt_q == DIR_W'(PROF - 1)) begin
                    estado_d = FIN;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                estado_d = REPOSO;
                cnt_d    = '0;
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        OCUPADO_BRP = 1'b0;
        FIN_BRP     = 1'b0;
        unique case (estado_q)
            BARRIDO: OCUPADO_BRP = 1'b1;
            FIN:     FIN_BRP     = 1'b1;
            default: ;
        endcase
    end

    // Storage: sweep zeroing has priority (WACK is low then anyway); writes to r0 dropped.
    always_ff @(posedge CLK_BRP or negedge RST_N_BRP) begin
        if (!RST_N_BRP) begin
            for (int i = 0; i < PROF; i++) begin
                mem_q[i] <= '0;
            end
        end else if (estado_q == BARRIDO) begin
            mem_q[cnt_q] <= '0;
        end else if (WACK_BRP && !wr_cero) begin
            mem_q[WA_BRP] <= DW_BRP;
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [DIR_W-1:0] dir_k;
        assign dir_k = RA_BRP[k*DIR_W +: DIR_W];

        // Read port k: zero register first, then same-cycle bypass, then storage.
        always_comb begin
            DR_BRP[k*ANCHO +: ANCHO] = mem_q[dir_k];
            if ((CERO_R0 != 0) && (dir_k == '0)) begin
                DR_BRP[k*ANCHO +: ANCHO] = '0;
            end else if ((BYPASS != 0) && WACK_BRP && (dir_k == WA_BRP)) begin
                DR_BRP[k*ANCHO +: ANCHO] = DW_BRP;
            end
        end
    end

endmodule

// File: tb/tb_banco_registros_param.sv
// Testbench for banco_registros_param with default parameters
// (32 x 32 bits, 2 read ports, zero register, bypass enabled).
module tb_banco_registros_param;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NP = 32;

    logic            clk;
    logic            rst_n;
    logic [2*AW-1:0] ra;
    logic [2*DW-1:0] dr;
    logic [AW-1:0]   wa;
    logic [DW-1:0]   dw;
    logic            we;
    logic            wack;
    logic            clr;
    logic            ocupado;
    logic            fin;

    int checks = 0;
    int errors = 0;

    // Reference model: contents, sweep progress, completion pulse.
    logic [DW-1:0] mem_m [NP];
    bit            sw_m;
    int            pos_m;
    bit            fin_m;

    banco_registros_param dut (
        .CLK_BRP     (clk),
        .RST_N_BRP   (rst_n),
        .RA_BRP      (ra),
        .DR_BRP      (dr),
        .WA_BRP      (wa),
        .DW_BRP      (dw),
        .WE_BRP      (we),
        .WACK_BRP    (wack),
        .CLR_BRP     (clr),
        .OCUPADO_BRP (ocupado),
        .FIN_BRP     (fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we && !sw_m && a == wa) return dw;
        return mem_m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) mem_m[i] = '0;
        sw_m  = 0;
        pos_m = 0;
        fin_m = 0;
    endtask

    // Compare every output against the model for the current inputs.
    task automatic check_outs(input string tag);
        #1;
        chk({tag, "_ocupado"}, 32'(ocupado), 32'(sw_m));
        chk({tag, "_fin"},     32'(fin),     32'(fin_m));
        chk({tag, "_wack"},    32'(wack),    32'(we && !sw_m));
        chk({tag, "_rd0"},     dr[0 +: DW],  exp_rd(ra[0 +: AW]));
        chk({tag, "_rd1"},     dr[DW +: DW], exp_rd(ra[AW +: AW]));
    endtask

    // Advance one clock edge, updating the model with the inputs present at that edge.
    task automatic edge_step();
        if (rst_n) begin
            if (sw_m) begin
                mem_m[pos_m] = '0;
                pos_m++;
                fin_m = 0;
                if (pos_m == NP) begin
                    sw_m  = 0;
                    fin_m = 1;
                end
            end else begin
                if (we && wa != 0) mem_m[wa] = dw;
                fin_m = 0;
                if (clr) begin
                    sw_m  = 1;
                    pos_m = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
    endtask

    initial begin
        int  busy_cnt;
        int  fin_cnt;
        bit  done;

        rst_n = 1'b0;
        we = 0; wa = '0; dw = '0; clr = 0; ra = '0;
        model_reset();

        // Reset: every address reads zero on both ports.
        for (int a = 0; a < NP; a++) begin
            set_ra(AW'(a), AW'(NP - 1 - a));
            check_outs("reset");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Bypass: write 0xDEADBEEF to 5, read it the same cycle.
        we = 1; wa = 5; dw = 32'hDEADBEEF; set_ra(5, 3);
        check_outs("bypass");
        chk("bypass_rd0", dr[0 +: DW], 32'hDEADBEEF);
        chk("bypass_wack", 32'(wack), 32'd1);
        edge_step();
        we = 0;
        check_outs("after_wr5");
        chk("stored_rd0", dr[0 +: DW], 32'hDEADBEEF);

        // Zero register: write acknowledged but dropped.
        we = 1; wa = 0; dw = 32'h12345678; set_ra(0, 0);
        check_outs("r0_wr");
        chk("r0_wack", 32'(wack), 32'd1);
        chk("r0_same", dr[DW +: DW], 32'd0);
        edge_step();
        we = 0;
        check_outs("r0_after");

        // Fill 1..31 with their address, reading random ports meanwhile.
        for (int a = 1; a < NP; a++) begin
            we = 1; wa = AW'(a); dw = 32'(a);
            set_ra(AW'($urandom_range(NP - 1)), AW'($urandom_range(NP - 1)));
            check_outs("fill");
            edge_step();
        end
        we = 0;

        // Clear sweep: busy exactly NP cycles, then a single FIN cycle.
        clr = 1;
        check_outs("clr_req");
        edge_step();
        clr = 0;
        busy_cnt = 0;
        fin_cnt  = 0;
        for (int n = 0; n < NP + 2; n++) begin
            if (n == 10) set_ra(9, 20);
            else set_ra(AW'($urandom_range(NP - 1)), AW'($urandom_range(NP - 1)));
            if (n == 5) clr = 1;
            else clr = 0;
            check_outs("sweep");
            if (n == 10) begin
                chk("sweep10_a9", dr[0 +: DW], 32'd0);
                chk("sweep10_a20", dr[DW +: DW], 32'd20);
            end
            if (ocupado) busy_cnt++;
            if (fin) fin_cnt++;
            edge_step();
        end
        clr = 0;
        chk("busy_cycles", 32'(busy_cnt), 32'(NP));
        chk("fin_cycles", 32'(fin_cnt), 32'd1);
        for (int a = 0; a < NP; a += 2) begin
            set_ra(AW'(a), AW'(a + 1));
            check_outs("post_clear");
        end

        // Write held through a sweep is accepted in the FIN cycle.
        we = 1; wa = 7; dw = 32'hA5A5A5A5; clr = 1; set_ra(7, 8);
        check_outs("hold_start");
        edge_step();
        clr = 0;
        done = 0;
        for (int n = 0; n < NP + 8 && !done; n++) begin
            check_outs("hold");
            if (fin) begin
                chk("hold_wack_fin", 32'(wack), 32'd1);
                done = 1;
            end else if (ocupado) begin
                chk("hold_wack_busy", 32'(wack), 32'd0);
            end
            edge_step();
        end
        chk("hold_fin_seen", 32'(done), 32'd1);
        we = 0;
        check_outs("hold_after");
        chk("hold_a7", dr[0 +: DW], 32'hA5A5A5A5);

        // Reset in the middle of a sweep.
        we = 1; wa = 30; dw = 32'hFF; set_ra(30, 7);
        edge_step();
        we = 0;
        check_outs("a30_written");
        clr = 1;
        edge_step();
        clr = 0;
        for (int n = 0; n < 12; n++) begin
            check_outs("pre_rst");
            edge_step();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        check_outs("mid_rst");
        chk("mid_rst_a30", dr[0 +: DW], 32'd0);
        chk("mid_rst_ocupado", 32'(ocupado), 32'd0);
        for (int n = 0; n < 3; n++) begin
            edge_step();
            check_outs("in_rst");
        end
        rst_n = 1'b1;
        for (int n = 0; n < NP + 2; n++) begin
            set_ra(AW'($urandom_range(NP - 1)), 30);
            check_outs("after_rst");
            edge_step();
        end

        // Randomised traffic with occasional clears.
        for (int n = 0; n < 400; n++) begin
            we  = 1'($urandom_range(1));
            wa  = AW'($urandom_range(NP - 1));
            dw  = $urandom;
            clr = ($urandom_range(39) == 0);
            if ($urandom_range(3) == 0) set_ra(wa, wa);
            else set_ra(AW'($urandom_range(NP - 1)), AW'($urandom_range(NP - 1)));
            check_outs("rand");
            edge_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/banco_registros_param.md
# banco_registros_param

Parametrised, clocked successor to the processor's register bank. It provides `NR` combinational read ports and one synchronous write port, with optional write-to-read bypass and an optional hard-wired zero register. A sequential clear engine re-zeroes the whole bank on request, one entry per cycle. It sits between the decode stage (read addresses) and the write-back stage (write address/data).

## Interface
Parameters:
- `ANCHO` (default 32): data width per register.
- `PROF` (default 32): number of registers; power of two, at least 2.
- `DIR_W` (default $clog2(PROF)): address width; derived, not overridden.
- `NR` (default 2): number of read ports, 1–4.
- `CERO_R0` (default 1): if 1, register 0 always reads 0 and writes to it are dropped.
- `BYPASS` (default 1): if 1, a read of the address being written this cycle returns `DW_BRP`.

Ports:
- `CLK_BRP` input 1: single clock; rising edge.
- `RST_N_BRP` input 1: asynchronous, active-low reset.
- `RA_BRP` input NR*DIR_W: read addresses, flattened; port k uses bits [k*DIR_W +: DIR_W].
- `DR_BRP` output NR*ANCHO: read data, flattened the same way.
- `WA_BRP` input DIR_W: write address.
- `DW_BRP` input ANCHO: write data.
- `WE_BRP` input 1: write request.
- `WACK_BRP` output 1: write accepted this cycle (combinational; equals `WE_BRP & ~OCUPADO_BRP`).
- `CLR_BRP` input 1: clear request, sampled on the clock edge.
- `OCUPADO_BRP` output 1: clear engine active.
- `FIN_BRP` output 1: one-cycle pulse after the last entry is cleared.

## Operation
- Storage: `PROF` x `ANCHO` flops.
  - Reset asserted: all entries become 0 asynchronously.
  - FSM returns to REPOSO, sweep counter returns to 0.
  - `OCUPADO_BRP`=0, `FIN_BRP`=0.
- Write:
  - On a rising edge with `WACK_BRP`=1, `MEM[WA_BRP]` <= `DW_BRP`.
  - If `CERO_R0`=1 and `WA_BRP`=0, the write is dropped, but `WACK_BRP` is still 1 (the write is acknowledged and discarded).
- Read, port k, purely combinational:
  - If `CERO_R0`=1 and the address is 0: result is 0.
  - Else if `BYPASS`=1, `WACK_BRP`=1 and the address equals `WA_BRP`: result is `DW_BRP`.
  - Else: result is `MEM[address]`.
  - Any number of ports may share an address; all return identical data.
- Clear FSM states: REPOSO, BARRIDO, FIN.
  - REPOSO -> BARRIDO when `CLR_BRP`=1 at an edge; counter is loaded with 0.
  - BARRIDO: each edge writes `MEM[cnt]` <= 0 and increments `cnt`. When `cnt`=PROF-1 is cleared, go to FIN. `OCUPADO_BRP`=1 throughout BARRIDO.
  - FIN: `FIN_BRP`=1 and `OCUPADO_BRP`=0 for exactly one cycle, then REPOSO. A `CLR_BRP` seen in FIN starts a new sweep (FIN -> BARRIDO).
  - `CLR_BRP` in BARRIDO is ignored; a sweep is never restarted or extended.
- Write/clear interaction:
  - The edge that samples `CLR_BRP` in REPOSO still accepts a coincident write, because `WACK_BRP` was 1 in that cycle.
  - That write is overwritten when the sweep reaches its address.
  - During BARRIDO, `WACK_BRP`=0. The producer must hold `WE_BRP`/`WA_BRP`/`DW_BRP` until it sees `WACK_BRP`=1.
- Reads during BARRIDO return current contents: already-swept entries read 0, the rest read their old values. Bypass is inactive during BARRIDO because `WACK_BRP`=0.
- Counter width: `DIR_W`. The terminal value is PROF-1, so the counter never wraps.

## Timing
- Read latency: 0 cycles (combinational from `RA_BRP`, storage, and the bypass inputs).
- Write latency: the entry is visible through storage on the cycle after acceptance. With `BYPASS`=1 it is also visible in the same cycle.
- Clear, with `CLR_BRP` sampled at edge E:
  - `OCUPADO_BRP` rises after E.
  - Entry i is zero after edge E+1+i.
  - `OCUPADO_BRP` falls and `FIN_BRP` rises after E+PROF.
  - `FIN_BRP` falls after E+PROF+1.
  - Total busy time: PROF cycles.
- Reset mid-sweep: immediate return to REPOSO with all entries 0. `FIN_BRP` is not pulsed.
- Reset release: the first write can be accepted at the first edge after `RST_N_BRP` rises.

## Test plan
- Reset, then read all 32 addresses on both ports -> every read is 0x00000000, `OCUPADO_BRP`=0, `FIN_BRP`=0.
- Write 0xDEADBEEF to address 5, with `RA` port0=5 in the same cycle:
  - `BYPASS`=1 -> port0 reads 0xDEADBEEF in that cycle, `WACK_BRP`=1.
  - `BYPASS`=0 -> port0 reads 0 in that cycle and 0xDEADBEEF on the next cycle.
- Write 0x12345678 to address 0 with `CERO_R0`=1 -> `WACK_BRP`=1, and all ports reading address 0 return 0 in that cycle and every later cycle.
- Fill addresses 1–31 with values equal to their address, then pulse `CLR_BRP`:
  - `OCUPADO_BRP`=1 for exactly 32 cycles, then `FIN_BRP`=1 for 1 cycle.
  - At sweep cycle 10, address 9 reads 0 and address 20 reads 20.
  - After completion, all addresses read 0.
- Hold `WE_BRP`=1, `WA_BRP`=7, `DW_BRP`=0xA5A5A5A5 during a sweep:
  - `WACK_BRP`=0 throughout BARRIDO.
  - The write is accepted in the FIN cycle.
  - Address 7 reads 0xA5A5A5A5 afterwards.
- Assert `RST_N_BRP`=0 at sweep cycle 12 after writing 0xFF to address 30 -> asynchronous clear; `OCUPADO_BRP`=0 immediately, address 30 reads 0, and no `FIN_BRP` pulse occurs.
